uart_rx_param: RTL and testbench

- Parametrised UART receiver that turns the calculator's serial rxd line into data words, with a valid/ready handshake toward the command parser.
- Successor to the fixed 8N1, 16-clocks-per-bit receive path in the UART calculator top.
- Adds configurable bit period, word width, parity and stop bits, 3-sample majority vote, start-glitch rejection, and frame/parity/overrun error flags.
- Sits between the rxd pin and the calculator FSM.

---
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param.sv | 139 +++++++++++++
 tb/tb_uart_rx_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line plus word handshake and error strobes of the UART receiver
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        input  rxd, rx_ready,
        output rx_data, rx_valid, frame_err, parity_err, overrun_err, busy
    );

    modport slave (
        output rxd, rx_ready,
        input  rx_data, rx_valid, frame_err, parity_err, overrun_err, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling, error strobes and valid/ready output
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    uart_rx_param_if.master   bus
);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam int CW  = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH} state_t;

    state_t               r_state;
    logic                 r_sync1, r_sync2, r_rs_d;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_s0, r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err, r_parity_err, r_overrun_err;
    logic                 w_rs, w_maj, w_dec, w_end;

    assign w_rs  = r_sync2;
    assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rs) | (r_s1 & w_rs);
    assign w_dec = r_cnt == CW'(MID + 1);
    assign w_end = r_cnt == CW'(CLKS_PER_BIT - 1);

    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.parity_err  = r_parity_err;
    assign bus.overrun_err = r_overrun_err;
    assign bus.busy        = r_state != S_IDLE;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rs_d  <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
            r_rs_d  <= r_sync2;
        end
    end

    // Frame FSM: bit timing, vote capture, shifting, word completion and output handshake
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_s0          <= 1'b1;
            r_s1          <= 1'b1;
            r_shift       <= '0;
            r_par_bad     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
            if (r_rx_valid && bus.rx_ready)
                r_rx_valid <= 1'b0;
            if (r_cnt == CW'(MID - 1))
                r_s0 <= w_rs;
            if (r_cnt == CW'(MID))
                r_s1 <= w_rs;
            r_cnt <= (r_state == S_IDLE || w_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_rs_d && !w_rs) begin
                        r_state   <= S_START;
                        r_bit_idx <= '0;
                        r_par_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_maj)
                        r_state <= S_IDLE;
                    else if (w_end)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_dec)
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    if (w_end) begin
                        if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (w_dec)
                        r_par_bad <= ^r_shift ^ w_maj ^ (PARITY == 2);
                    if (w_end)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_dec && !w_maj) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_WAIT_HIGH;
                    end else if (w_dec && r_bit_idx == 4'(STOP_BITS - 1)) begin
                        // Leave at mid-bit so a following start bit is caught with no idle gap
                        r_state <= S_IDLE;
                        if (r_par_bad) begin
                            r_parity_err <= 1'b1;
                        end else if (!r_rx_valid || bus.rx_ready) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_overrun_err <= 1'b1;
                        end
                    end else if (w_end) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rs)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames against a word/error reference model
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_param_if #(.DATA_BITS(8)) a_if();
    uart_rx_param_if #(.DATA_BITS(7)) b_if();

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .n_rst(n_rst), .bus(a_if.master));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
        dut_b (.clk(clk), .n_rst(n_rst), .bus(b_if.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int a_got[$], a_exp[$], b_got[$], b_exp[$];
    int a_ferr = 0, a_perr = 0, a_ovr = 0, b_ferr = 0, b_perr = 0, b_ovr = 0;
    int a_rise = 0;
    logic a_prev = 1'b0;

    always @(negedge clk) begin
        if (a_if.rx_valid === 1'b1 && a_if.rx_ready === 1'b1) a_got.push_back(int'(a_if.rx_data));
        if (b_if.rx_valid === 1'b1 && b_if.rx_ready === 1'b1) b_got.push_back(int'(b_if.rx_data));
        if (a_if.rx_valid === 1'b1 && !a_prev) a_rise = cyc;
        a_prev = a_if.rx_valid === 1'b1;
        a_ferr += int'(a_if.frame_err === 1'b1);
        a_perr += int'(a_if.parity_err === 1'b1);
        a_ovr  += int'(a_if.overrun_err === 1'b1);
        b_ferr += int'(b_if.frame_err === 1'b1);
        b_perr += int'(b_if.parity_err === 1'b1);
        b_ovr  += int'(b_if.overrun_err === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_a(input logic v, input int n);
        a_if.rxd = v;
        tick(n);
    endtask

    task automatic drive_b(input logic v, input int n);
        b_if.rxd = v;
        tick(n);
    endtask

    // One 8N1 frame; a set bit in spikes puts a one-cycle low pulse at mid-bit of that data bit
    task automatic send_a(input int data, input logic stop, input int spikes);
        drive_a(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if ((spikes >> i) & 1) begin
                drive_a(1'((data >> i) & 1), 9);
                drive_a(1'b0, 1);
                drive_a(1'((data >> i) & 1), 6);
            end else begin
                drive_a(1'((data >> i) & 1), 16);
            end
        end
        drive_a(stop, 16);
    endtask

    task automatic send_b(input int data, input logic par);
        drive_b(1'b0, 16);
        for (int i = 0; i < 7; i++) drive_b(1'((data >> i) & 1), 16);
        drive_b(par, 16);
        drive_b(1'b1, 16);
    endtask

    task automatic check_a(input string tag);
        check({tag, "_a_count"}, a_got.size(), a_exp.size());
        for (int i = 0; i < a_exp.size() && i < a_got.size(); i++)
            check($sformatf("%s_a_word%0d", tag, i), a_got[i], a_exp[i]);
    endtask

    task automatic check_b(input string tag);
        check({tag, "_b_count"}, b_got.size(), b_exp.size());
        for (int i = 0; i < b_exp.size() && i < b_got.size(); i++)
            check($sformatf("%s_b_word%0d", tag, i), b_got[i], b_exp[i]);
    endtask

    initial begin
        int t0, lat, d, p, exp_perr;
        int str[14] = '{8'h49, 8'h20, 8'h53, 8'h20, 8'h66, 8'h66, 8'h66,
                        8'h35, 8'h2B, 8'h30, 8'h30, 8'h30, 8'h34, 8'h3D};
        a_if.rxd = 1'b1; a_if.rx_ready = 1'b1;
        b_if.rxd = 1'b1; b_if.rx_ready = 1'b1;
        tick(3);
        check("rst_data", a_if.rx_data, 0);
        check("rst_valid", a_if.rx_valid, 0);
        check("rst_busy", a_if.busy, 0);
        check("rst_errs", {a_if.frame_err, a_if.parity_err, a_if.overrun_err}, 0);
        n_rst = 1'b1;
        tick(20);

        t0 = cyc;
        send_a(8'h49, 1'b1, 0);
        a_exp.push_back(8'h49);
        tick(20);
        lat = a_rise - t0;
        check("latency_in_range", (lat >= 154 && lat <= 158), 1);
        check_a("single");

        foreach (str[i]) begin
            send_a(str[i], 1'b1, 0);
            a_exp.push_back(str[i]);
        end
        tick(20);
        check_a("string");

        drive_a(1'b0, 3);
        drive_a(1'b1, 16);
        check("glitch_busy", a_if.busy, 0);
        check("glitch_valid", a_if.rx_valid, 0);
        d = 8'hFF;
        send_a(d, 1'b1, 8'hFF);
        a_exp.push_back(d);
        tick(20);
        check_a("glitch_spike");

        send_a(8'h55, 1'b0, 0);
        drive_a(1'b0, 40);
        drive_a(1'b1, 20);
        check("frame_err_count", a_ferr, 1);
        check_a("frame_err");
        send_a(8'h2D, 1'b1, 0);
        a_exp.push_back(8'h2D);
        tick(20);
        check_a("after_break");

        a_if.rx_ready = 1'b0;
        send_a(8'h30, 1'b1, 0);
        send_a(8'h31, 1'b1, 0);
        tick(20);
        check("ovr_valid", a_if.rx_valid, 1);
        check("ovr_data", a_if.rx_data, 8'h30);
        check("ovr_count", a_ovr, 1);
        a_if.rx_ready = 1'b1;
        tick(1);
        a_if.rx_ready = 1'b0;
        tick(1);
        check("ovr_cleared", a_if.rx_valid, 0);
        a_exp.push_back(8'h30);
        a_if.rx_ready = 1'b1;

        for (int k = 0; k < 8; k++) begin
            d = int'($urandom_range(0, 255));
            send_a(d, 1'b1, int'($urandom_range(0, 255)));
            a_exp.push_back(d);
        end
        tick(20);
        check_a("random");
        check("a_ferr_total", a_ferr, 1);
        check("a_perr_total", a_perr, 0);
        check("a_ovr_total", a_ovr, 1);

        send_b(7'h41, 1'b0);
        tick(20);
        check("b_parity_err", b_perr, 1);
        check_b("b_bad_parity");
        exp_perr = 1;
        for (int k = 0; k < 6; k++) begin
            d = int'($urandom_range(0, 127));
            p = int'($urandom_range(0, 1));
            send_b(d, 1'(p));
            if (($countones(d) + p) % 2 == 1) b_exp.push_back(d);
            else exp_perr++;
        end
        tick(20);
        check("b_perr_random", b_perr, exp_perr);
        check_b("b_random");

        drive_b(1'b0, 16);
        drive_b(1'b1, 16);
        drive_b(1'b0, 20);
        n_rst = 1'b0;
        b_if.rxd = 1'b1;
        tick(2);
        check("b_rst_data", b_if.rx_data, 0);
        check("b_rst_outs", {b_if.rx_valid, b_if.busy, b_if.frame_err, b_if.parity_err, b_if.overrun_err}, 0);
        n_rst = 1'b1;
        tick(30);
        check("b_idle_busy", b_if.busy, 0);
        send_b(7'h41, 1'b1);
        b_exp.push_back(7'h41);
        tick(20);
        check_b("b_after_reset");
        check("b_ferr_total", b_ferr, 0);
        check("b_ovr_total", b_ovr, 0);
        check("b_perr_total", b_perr, exp_perr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
